// File: rtl/calc_key_sequencer.sv
// Keypad-to-datapath sequencer: accumulates decimal operands and issues
// STORE/UPDATE/SHOW/RESET commands over a valid/ready handshake.
module calc_key_sequencer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             key_ready,
    output logic             cmd_valid,
    output logic [1:0]       cmd_op,
    output logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_ready,
    output logic [2:0]       digit_cnt,
    output logic             overflow,
    output logic             show_on
);

    typedef enum logic [1:0] {StIdle, StEntry, StIssue} state_t;

    localparam logic [1:0] OpStore  = 2'b00;
    localparam logic [1:0] OpUpdate = 2'b01;
    localparam logic [1:0] OpShow   = 2'b10;
    localparam logic [1:0] OpReset  = 2'b11;

    localparam logic [3:0] KeyEnter = 4'hA;
    localparam logic [3:0] KeyTotal = 4'hB;
    localparam logic [3:0] KeyClear = 4'hC;

    state_t           state;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] operand_next;
    logic             stored_flag;
    logic             is_digit;
    logic             room;

    assign key_ready = (state != StIssue);
    assign cmd_valid = (state == StIssue);

    // Truncation of operand*10+d to WIDTH bits equals reducing modulo 2^WIDTH.
    assign operand_next = operand * WIDTH'(10) + WIDTH'(key_code);
    assign is_digit     = (key_code < 4'd10);
    assign room         = (digit_cnt < 3'(MAX_DIGITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            operand     <= '0;
            digit_cnt   <= '0;
            overflow    <= 1'b0;
            show_on     <= 1'b0;
            stored_flag <= 1'b0;
            cmd_op      <= OpStore;
            cmd_data    <= '0;
        end else begin
            unique case (state)
                StIdle, StEntry: begin
                    if (key_valid) begin
                        if (is_digit) begin
                            if (room) begin
                                operand   <= operand_next;
                                digit_cnt <= digit_cnt + 3'd1;
                                state     <= StEntry;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (key_code == KeyEnter) begin
                            if (state == StEntry) begin
                                cmd_op   <= stored_flag ? OpUpdate : OpStore;
                                cmd_data <= operand;
                                state    <= StIssue;
                            end
                        end else if (key_code == KeyTotal) begin
                            cmd_op   <= OpShow;
                            cmd_data <= '0;
                            state    <= StIssue;
                        end else if (key_code == KeyClear) begin
                            cmd_op   <= OpReset;
                            cmd_data <= '0;
                            state    <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    if (cmd_ready) begin
                        cmd_data <= '0;
                        unique case (cmd_op)
                            OpStore, OpUpdate: begin
                                stored_flag <= 1'b1;
                                operand     <= '0;
                                digit_cnt   <= '0;
                                overflow    <= 1'b0;
                                state       <= StIdle;
                            end
                            OpShow: begin
                                show_on <= ~show_on;
                                state   <= (digit_cnt != 3'd0) ? StEntry : StIdle;
                            end
                            OpReset: begin
                                stored_flag <= 1'b0;
                                operand     <= '0;
                                digit_cnt   <= '0;
                                overflow    <= 1'b0;
                                show_on     <= 1'b0;
                                state       <= StIdle;
                            end
                        endcase
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
